mac_mul_stage: RTL and testbench
================================

Name: mac_mul_stage

Overview:
- Front end of the MAC datapath. Accepts operand pairs, multiplies them in a pipelined FP_MUL unit, and buffers the products in a credit-protected output FIFO.
- Drives the accumulator's DataInValid/DataIn and obeys its DataInRdy.
- The accumulator deasserts ready for its full add latency, and FP_MUL has no stall input. This block absorbs that backpressure without dropping or reordering products.

Parameters:
- DataWidth, 32, operand/product width (IEEE-754 single).
- Mul_Stages, 5, fixed FP_MUL latency in cycles.
- FifoDepth, 8, output FIFO entries; must be >= 2.
- FifoDepthWidth, 3, log2(FifoDepth); pointer width.

Ports:
- clk  input  1  clock.
- aclr  input  1  synchronous active-high reset.
- DataInValid  input  1  operand pair valid.
- DataInA  input  DataWidth  multiplicand.
- DataInB  input  DataWidth  multiplier.
- DataInRdy  output  1  block can accept a pair this cycle.
- DataOutValid  output  1  product available (to ACC DataInValid).
- DataOutRdy  input  1  consumer accepts (from ACC DataInRdy).
- DataOut  output  DataWidth  product at FIFO head.

Behaviour:
- Reset: one clock; reset is synchronous and active-high, sampled on the rising edge of clk while aclr is high. It clears the valid pipe, InFlight, Count, WrPtr and RdPtr.
- Outputs after reset: DataOutValid=0 and DataOut=0. DataInRdy=0 while aclr is high, and DataInRdy=1 in the first cycle after aclr falls.
- Accept: Accept = DataInValid & DataInRdy. DataInA/DataInB go to FP_MUL in that cycle. A 1 enters a Mul_Stages-deep valid shift register; otherwise a 0 enters.
- FP_MUL instance ports: aclr tied to aclr, clock tied to clk, dataa, datab, result.
- Credit rule: DataInRdy = (InFlight + Count) < FifoDepth.
  - InFlight = number of 1s in the valid pipe. Keep it as a counter: +1 on Accept, -1 when a 1 exits the pipe.
  - DataInRdy depends on registers only; it has no combinational path from DataInValid or DataOutRdy.
  - The credit rule guarantees the FIFO never overflows.
- Pipe exit: when a 1 exits the valid pipe, FP_MUL result is written at WrPtr, WrPtr increments, and Count increments.
- Output, first-word-fall-through:
  - DataOutValid = (Count != 0).
  - DataOut = Mem[RdPtr] when Count != 0, else 0.
  - Pop = DataOutValid & DataOutRdy; it increments RdPtr and decrements Count.
- Latency: an accept at edge t is written at edge t+Mul_Stages. DataOutValid is high in the following cycle, so the first product appears Mul_Stages+1 cycles after acceptance.
- Throughput: 1 pair per cycle with DataOutRdy held high if FifoDepth >= Mul_Stages+2. Defaults satisfy this.
- Boundary conditions:
  - Pointers wrap modulo FifoDepth.
  - Push and pop in the same cycle leave Count unchanged.
  - Pop while empty is ignored.
  - Accept and pipe exit in the same cycle leave InFlight unchanged.
  - Products are delivered strictly in acceptance order.
  - DataOutValid is held high until the pop handshake occurs.
- Reset mid-operation: all in-flight and buffered products are discarded. Stale FP_MUL results still emerging are ignored because the valid pipe has been cleared.
- No NaN/denormal handling here; that is the FP_MUL behaviour.

Optional Feature:
- Macro MAC_MUL_LEVEL_EN.
- Defined: adds output port FifoLevel, FifoDepthWidth+1 bits, equal to Count (reset 0). Adds output port InRdyStall, 1 bit, high in any cycle with DataInValid & ~DataInRdy.
- Undefined: neither port exists; core behaviour is identical.

Decomposition:
- Shared package mac_pkg holds:
  - DATA_WIDTH=32
  - MUL_STAGES=5
  - ADD_STAGES=7
  - FP constants FP_ONE=32'h3F800000, FP_TWO=32'h40000000, FP_THREE=32'h40400000, FP_SIX=32'h40C00000
  - a clog2 helper used to derive FifoDepthWidth
- The valid shift register reuses the existing NOPPipeline with Stages=Mul_Stages, driven with ~Accept.
- One sub-module is natural: mac_mul_fifo (FWFT FIFO holding Mem, pointers and Count, with push/pop/empty/count).

Test Plan:
- Single pair: A=0x40000000, B=0x40400000 accepted at edge 0 -> DataOutValid rises after edge 5 (Mul_Stages). DataOut=0x40C00000 with DataOutRdy=1, then DataOutValid=0 next cycle.
- Streaming: 20 pairs (A=1.0, B=k as float for k=1..20), DataInValid and DataOutRdy held high -> DataInRdy never drops; products 1.0..20.0 appear in order on 20 consecutive cycles.
- Backpressure: DataOutRdy=0 while DataInValid held high -> exactly 8 accepts, then DataInRdy=0 while InFlight+Count=8. No product is lost when DataOutRdy later returns to 1, and all 8 are drained in order.
- ACC-paced: connect to ACC (7 stages, AccumulateCount=2) with 6 pairs of 1.0*1.0 -> ACC emits 2.0 three times; no FIFO overflow (assertion on Count <= FifoDepth).
- Reset mid-stream: aclr asserted for 1 cycle with 3 in flight and 2 buffered -> DataOutValid=0 and Count=0 the next cycle. No stale product appears in the following 10 cycles, and DataInRdy=1.
- Simultaneous push/pop with Count=1 and DataOutRdy=1 -> Count stays 1 and order is preserved. With MAC_MUL_LEVEL_EN defined, FifoLevel reads 1 throughout.

Source files
------------

// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared MAC datapath constants and sizing helper
package mac_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int MUL_STAGES = 5;
    localparam int ADD_STAGES = 7;

    localparam logic [31:0] FP_ONE   = 32'h3F800000;
    localparam logic [31:0] FP_TWO   = 32'h40000000;
    localparam logic [31:0] FP_THREE = 32'h40400000;
    localparam logic [31:0] FP_SIX   = 32'h40C00000;

    function automatic int mac_clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/FP_MUL.sv
// rtl/FP_MUL.sv - IEEE-754 single multiplier, round-to-nearest-even, fixed latency, no stall
module FP_MUL #(
    parameter int Stages = 5
) (
    input  logic        aclr,
    input  logic        clock,
    input  logic [31:0] dataa,
    input  logic [31:0] datab,
    output logic [31:0] result
);

    logic              sign;
    logic [7:0]        ea, eb;
    logic [47:0]       prod;
    logic [22:0]       frac;
    logic              guard, sticky, round_up;
    logic [23:0]       frac_r;
    logic signed [9:0] exp_s;
    logic [31:0]       product;
    logic [31:0]       pipe_q [Stages];

    // Denormal inputs flush to zero; overflow saturates to infinity.
    always_comb begin
        sign  = dataa[31] ^ datab[31];
        ea    = dataa[30:23];
        eb    = datab[30:23];
        prod  = {24'd0, 1'b1, dataa[22:0]} * {24'd0, 1'b1, datab[22:0]};
        if (prod[47]) begin
            frac   = prod[46:24];
            guard  = prod[23];
            sticky = |prod[22:0];
            exp_s  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd126;
        end else begin
            frac   = prod[45:23];
            guard  = prod[22];
            sticky = |prod[21:0];
            exp_s  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
        end
        round_up = guard & (sticky | frac[0]);
        frac_r   = {1'b0, frac} + {23'd0, round_up};
        if (frac_r[23]) exp_s = exp_s + 10'sd1;
        if (ea == 8'd0 || eb == 8'd0 || exp_s <= 10'sd0)
            product = {sign, 31'd0};
        else if (exp_s >= 10'sd255)
            product = {sign, 8'hFF, 23'd0};
        else
            product = {sign, exp_s[7:0], frac_r[22:0]};
    end

    always_ff @(posedge clock) begin
        if (aclr) begin
            for (int i = 0; i < Stages; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= product;
            for (int i = 1; i < Stages; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign result = pipe_q[Stages-1];

endmodule

// File: rtl/NOPPipeline.sv
// rtl/NOPPipeline.sv - fixed-depth shift register of no-op flags, reset to all no-op
module NOPPipeline #(
    parameter int Stages = 5
) (
    input  logic clk,
    input  logic aclr,
    input  logic NopIn,
    output logic NopOut
);

    logic [Stages-1:0] nop_q;

    always_ff @(posedge clk) begin
        if (aclr) begin
            nop_q <= '1;
        end else begin
            nop_q[0] <= NopIn;
            for (int i = 1; i < Stages; i++) nop_q[i] <= nop_q[i-1];
        end
    end

    assign NopOut = nop_q[Stages-1];

endmodule

// File: rtl/mac_mul_fifo.sv
// rtl/mac_mul_fifo.sv - first-word-fall-through product FIFO with occupancy count
module mac_mul_fifo #(
    parameter int DataWidth = 32,
    parameter int Depth     = 8,
    parameter int PtrWidth  = 3
) (
    input  logic                 clk,
    input  logic                 aclr,
    input  logic                 push,
    input  logic [DataWidth-1:0] push_data,
    input  logic                 pop,
    output logic [DataWidth-1:0] head_data,
    output logic                 empty,
    output logic [PtrWidth:0]    count
);

    localparam logic [PtrWidth-1:0] PTR_LAST = PtrWidth'(Depth - 1);
    localparam logic [PtrWidth-1:0] PTR_ONE  = PtrWidth'(1);
    localparam logic [PtrWidth:0]   CNT_ONE  = (PtrWidth + 1)'(1);

    logic [DataWidth-1:0] mem [Depth];
    logic [PtrWidth-1:0]  wr_ptr, rd_ptr;
    logic                 do_pop;

    // The upstream credit check keeps push from ever hitting a full FIFO.
    assign empty  = (count == '0);
    assign do_pop = pop & ~empty;

    always_ff @(posedge clk) begin
        if (aclr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)   wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_ONE;
            if (do_pop) rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_ONE;
            case ({push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/mac_mul_stage.sv
// rtl/mac_mul_stage.sv - operand multiply front end with credit-protected output FIFO (option MAC_MUL_LEVEL_EN)
module mac_mul_stage
    import mac_pkg::*;
#(
    parameter int DataWidth      = DATA_WIDTH,
    parameter int Mul_Stages     = MUL_STAGES,
    parameter int FifoDepth      = 8,
    parameter int FifoDepthWidth = mac_clog2(FifoDepth)
) (
    input  logic                 clk,
    input  logic                 aclr,
    input  logic                 DataInValid,
    input  logic [DataWidth-1:0] DataInA,
    input  logic [DataWidth-1:0] DataInB,
    output logic                 DataInRdy,
    output logic                 DataOutValid,
    input  logic                 DataOutRdy,
    output logic [DataWidth-1:0] DataOut
`ifdef MAC_MUL_LEVEL_EN
    ,
    output logic [FifoDepthWidth:0] FifoLevel,
    output logic                    InRdyStall
`endif
);

    localparam logic [FifoDepthWidth:0]   CNT_ONE    = (FifoDepthWidth + 1)'(1);
    localparam logic [FifoDepthWidth+1:0] CREDIT_MAX = (FifoDepthWidth + 2)'(FifoDepth);

    logic                    accept, pipe_nop_out, pipe_exit, pop, fifo_empty;
    logic [DataWidth-1:0]    mul_result;
    logic [FifoDepthWidth:0] in_flight, count;
    logic [FifoDepthWidth+1:0] credit_used;

    assign accept      = DataInValid & DataInRdy;
    assign pipe_exit   = ~pipe_nop_out;
    assign credit_used = {1'b0, in_flight} + {1'b0, count};
    // Every accepted pair owns a FIFO slot before it enters FP_MUL, which cannot stall.
    assign DataInRdy   = ~aclr & (credit_used < CREDIT_MAX);

    FP_MUL #(
        .Stages (Mul_Stages)
    ) u_fp_mul (
        .aclr   (aclr),
        .clock  (clk),
        .dataa  (DataInA),
        .datab  (DataInB),
        .result (mul_result)
    );

    NOPPipeline #(
        .Stages (Mul_Stages)
    ) u_valid_pipe (
        .clk    (clk),
        .aclr   (aclr),
        .NopIn  (~accept),
        .NopOut (pipe_nop_out)
    );

    always_ff @(posedge clk) begin
        if (aclr)
            in_flight <= '0;
        else if (accept & ~pipe_exit)
            in_flight <= in_flight + CNT_ONE;
        else if (~accept & pipe_exit)
            in_flight <= in_flight - CNT_ONE;
    end

    mac_mul_fifo #(
        .DataWidth (DataWidth),
        .Depth     (FifoDepth),
        .PtrWidth  (FifoDepthWidth)
    ) u_fifo (
        .clk       (clk),
        .aclr      (aclr),
        .push      (pipe_exit),
        .push_data (mul_result),
        .pop       (pop),
        .head_data (DataOut),
        .empty     (fifo_empty),
        .count     (count)
    );

    assign DataOutValid = ~fifo_empty;
    assign pop          = DataOutValid & DataOutRdy;

`ifdef MAC_MUL_LEVEL_EN
    assign FifoLevel  = count;
    assign InRdyStall = DataInValid & ~DataInRdy;
`endif

endmodule

// File: tb/tb_mac_mul_stage.sv
// tb/tb_mac_mul_stage.sv - scoreboard bench for mac_mul_stage
module tb_mac_mul_stage;

    localparam logic [31:0] FP_ONE   = 32'h3F800000;
    localparam logic [31:0] FP_TWO   = 32'h40000000;
    localparam logic [31:0] FP_THREE = 32'h40400000;
    localparam logic [31:0] FP_SIX   = 32'h40C00000;

    logic        clk = 1'b0;
    logic        aclr;
    logic        DataInValid;
    logic [31:0] DataInA, DataInB;
    logic        DataInRdy;
    logic        DataOutValid;
    logic        DataOutRdy;
    logic [31:0] DataOut;
`ifdef MAC_MUL_LEVEL_EN
    logic [3:0]  fifo_level;
    logic        in_rdy_stall;
`endif

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] exp_q[$];
    logic [31:0] expv;
    int          last_accept_cyc, last_pop_cyc, pop_count, stale_seen;
    int          run_len, max_run;
    bit          prev_pop;

    mac_mul_stage dut (
        .clk          (clk),
        .aclr         (aclr),
        .DataInValid  (DataInValid),
        .DataInA      (DataInA),
        .DataInB      (DataInB),
        .DataInRdy    (DataInRdy),
        .DataOutValid (DataOutValid),
        .DataOutRdy   (DataOutRdy),
        .DataOut      (DataOut)
`ifdef MAC_MUL_LEVEL_EN
        ,
        .FifoLevel    (fifo_level),
        .InRdyStall   (in_rdy_stall)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] itof(input int k);
        int          p;
        logic [31:0] m;
        p = 0;
        for (int i = 0; i < 31; i++) if ((k >> i) != 0) p = i;
        m = k;
        m = (m << (23 - p)) & 32'h007FFFFF;
        return {1'b0, 8'(127 + p), m[22:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: every output handshake is compared with the scoreboard head.
    always @(negedge clk) begin
        if (!aclr) begin
            assert (dut.u_fifo.count <= 8)
            else begin
                errors++;
                $display("FAIL fifo_overflow: count %0d exceeds 8", dut.u_fifo.count);
            end
            if (DataOutValid && DataOutRdy) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    stale_seen++;
                    $display("FAIL unexpected_output: got %h with empty scoreboard", DataOut);
                end else begin
                    expv = exp_q.pop_front();
                    if (DataOut !== expv) begin
                        errors++;
                        $display("FAIL product_order: got %h expected %h", DataOut, expv);
                    end
                end
                last_pop_cyc = cyc;
                pop_count++;
                run_len = prev_pop ? run_len + 1 : 1;
                if (run_len > max_run) max_run = run_len;
                prev_pop = 1'b1;
            end else begin
                prev_pop = 1'b0;
            end
        end else begin
            prev_pop = 1'b0;
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] req,
                        output int waited);
        waited      = 0;
        DataInValid = 1'b1;
        DataInA     = a;
        DataInB     = b;
        @(negedge clk);
        while (!DataInRdy && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!DataInRdy) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: DataInRdy %0b expected 1", DataInRdy);
            DataInValid = 1'b0;
        end else begin
            exp_q.push_back(req);
            last_accept_cyc = cyc + 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            #2;
            n++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int waited, total_waited, accepts, k, got;

        aclr = 1'b1; DataInValid = 1'b0; DataInA = '0; DataInB = '0; DataOutRdy = 1'b0;
        pop_count = 0; stale_seen = 0; run_len = 0; max_run = 0; prev_pop = 1'b0;
        last_accept_cyc = 0; last_pop_cyc = 0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_rdy", 32'(DataInRdy), 32'd0);
        check("rst_out_valid", 32'(DataOutValid), 32'd0);
        check("rst_out_data", DataOut, 32'd0);
        @(posedge clk); #1;
        aclr = 1'b0;
        @(negedge clk);
        check("post_rst_in_rdy", 32'(DataInRdy), 32'd1);
        @(posedge clk); #1;

        // Single pair: 2.0 * 3.0
        DataOutRdy = 1'b1;
        send(FP_TWO, FP_THREE, FP_SIX, waited);
        DataInValid = 1'b0;
        drain("single_drain", 20);
        check("single_latency", 32'(last_pop_cyc - last_accept_cyc), 32'd5);
        @(negedge clk);
        check("single_valid_low", 32'(DataOutValid), 32'd0);
        @(posedge clk); #1;

        // Streaming 1.0 * k
        total_waited = 0;
        max_run = 0;
        for (int i = 1; i <= 20; i++) begin
            send(FP_ONE, itof(i), itof(i), waited);
            total_waited += waited;
        end
        DataInValid = 1'b0;
        drain("stream_drain", 30);
        check("stream_no_stall", 32'(total_waited), 32'd0);
        check("stream_consecutive", 32'(max_run), 32'd20);

        // Backpressure: consumer blocked
        DataOutRdy  = 1'b0;
        accepts     = 0;
        k           = 1;
        DataInValid = 1'b1;
        DataInA     = FP_TWO;
        DataInB     = itof(k);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (DataInRdy) begin
                exp_q.push_back(itof(2 * k));
                accepts++;
            end
            @(posedge clk); #1;
            if (accepts == k) begin
                k++;
                DataInB = itof(k);
            end
        end
        @(negedge clk);
        check("bp_accepts", 32'(accepts), 32'd8);
        check("bp_in_rdy_low", 32'(DataInRdy), 32'd0);
`ifdef MAC_MUL_LEVEL_EN
        check("bp_level", 32'(fifo_level), 32'd8);
        check("bp_stall_flag", 32'(in_rdy_stall), 32'd1);
`endif
        @(posedge clk); #1;
        DataInValid = 1'b0;
        DataOutRdy  = 1'b1;
        drain("bp_drain", 30);

        // Accumulator-paced consumer: ready drops for 7 cycles after each take
        got = 0;
        DataOutRdy = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) send(FP_ONE, FP_ONE, FP_ONE, waited);
                DataInValid = 1'b0;
            end
            begin
                for (int j = 0; j < 6; j++) begin
                    int w;
                    w = 0;
                    DataOutRdy = 1'b1;
                    @(negedge clk);
                    while (!DataOutValid && w < 100) begin
                        @(negedge clk);
                        w++;
                    end
                    if (DataOutValid) got++;
                    @(posedge clk); #1;
                    DataOutRdy = 1'b0;
                    repeat (7) @(posedge clk);
                    #1;
                end
            end
        join
        check("acc_sums_emitted", 32'(got / 2), 32'd3);
        DataOutRdy = 1'b1;
        drain("acc_drain", 20);

        // Reset with 3 in flight and 2 buffered
        DataOutRdy = 1'b0;
        for (int i = 1; i <= 5; i++) send(FP_ONE, itof(i), itof(i), waited);
        DataInValid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        aclr = 1'b1;
        @(posedge clk); #1;
        aclr = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("midrst_out_valid", 32'(DataOutValid), 32'd0);
        check("midrst_count", 32'(dut.u_fifo.count), 32'd0);
        check("midrst_in_rdy", 32'(DataInRdy), 32'd1);
        stale_seen = 0;
        DataOutRdy = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("midrst_no_stale", 32'(stale_seen), 32'd0);

        // Simultaneous push/pop at Count=1
        for (int i = 3; i <= 8; i++) send(FP_TWO, itof(i), itof(2 * i), waited);
        DataInValid = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
`ifdef MAC_MUL_LEVEL_EN
            if (DataOutValid) check("pushpop_level", 32'(fifo_level), 32'd1);
`endif
            if (DataOutValid) check("pushpop_count", 32'(dut.u_fifo.count), 32'd1);
        end
        drain("pushpop_drain", 20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
